tpu_link_initiator: RTL and testbench
=====================================

TPU_LINK_INITIATOR -- requirements
Module: tpu_link_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning idle cycles allowed while awaiting any response byte.
REQ-002 SHALL have parameter PAYLOAD_WORDS, default 64, meaning 16-bit words per matrix transfer (2*PAYLOAD_WORDS bytes).
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request; cmd_op  in  8  opcode 0x01-0x08; cmd_ready  out  1  high only in IDLE.
REQ-006 tx_data  out  8  byte to link; tx_valid  out  1  byte offered; tx_ready  in  1  transfer when tx_valid&tx_ready.
REQ-007 rx_data  in  8  byte from link; rx_valid  in  1  single-cycle strobe, no backpressure.
REQ-008 src_rd  out  1  word read strobe; src_addr  out  6  word index; src_data  in  16  word, valid cycle after src_rd.
REQ-009 snk_we  out  1  word write strobe; snk_addr  out  6  word index; snk_data  out  16  received word.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse at command end; result  out  2  00 OK, 01 NACK, 10 TIMEOUT, 11 PROTOCOL, valid with done and held until next done.
REQ-012 status_byte  out  8 and cycle_count  out  24  last values returned by opcode 0x05, held until next 0x05.

Function
REQ-013 SHALL implement states IDLE, SEND_CMD, WAIT_ACK, FETCH, SEND_LO, SEND_HI, RECV_LO, RECV_HI, RECV_STAT, FINISH.
REQ-014 IDLE: on cmd_valid&cmd_ready latch cmd_op; opcode outside 0x01-0x08 -> FINISH with result 11, no byte sent.
REQ-015 Legal opcode accepted in cycle N -> tx_valid=1, tx_data=opcode in cycle N+1 (SEND_CMD).
REQ-016 tx_valid, once high, SHALL stay high with tx_data stable until tx_ready; no byte offered outside SEND_CMD/SEND_LO/SEND_HI.
REQ-017 WAIT_ACK: rx 0xAA -> next state by opcode; rx 0x55 -> FINISH result 01; any other byte -> FINISH result 11.
REQ-018 After ACK: 0x01/0x02 -> FETCH; 0x03/0x07/0x08 -> RECV_LO; 0x05 -> RECV_STAT; 0x04/0x06 -> FINISH result 00.
REQ-019 FETCH: src_rd=1 for one cycle with src_addr=word index, then SEND_LO with tx_data=src_data[7:0] registered from the next cycle.
REQ-020 SEND_HI sends src_data[15:8]; after accept, index+1; index reaching PAYLOAD_WORDS -> FINISH result 00, else FETCH.
REQ-021 Write transfer SHALL send words in index order 0..PAYLOAD_WORDS-1, low byte first, expecting no trailing response.
REQ-022 RECV_LO stores byte as low half; RECV_HI on rx_valid pulses snk_we with snk_data={rx_data,low}, snk_addr=index, same cycle as next-state update.
REQ-023 Read transfer ends with FINISH result 00 after word PAYLOAD_WORDS-1 written.
REQ-024 RECV_STAT takes exactly 4 bytes: byte0 -> status_byte, bytes1..3 -> cycle_count[7:0],[15:8],[23:16]; then FINISH result 00.
REQ-025 status_byte/cycle_count SHALL update only on completion of all 4 bytes; partial (timeout) keeps old values.
REQ-026 Timeout counter SHALL clear on state entry and on every rx_valid; while in WAIT_ACK/RECV_LO/RECV_HI/RECV_STAT, count reaching TIMEOUT_CYCLES-1 -> FINISH result 10.
REQ-027 Timeout SHALL NOT apply while waiting on tx_ready.
REQ-028 rx_valid in any state not awaiting a byte SHALL be ignored, no state change.
REQ-029 FINISH: done=1 one cycle, return to IDLE next cycle; cmd_ready=1 again that next cycle.
REQ-030 Word index width 6 bits; wrap never occurs since transfers end at PAYLOAD_WORDS.

Reset
REQ-031 rst high at any clock edge SHALL force IDLE, abort any transfer with no done pulse, and zero all outputs except cmd_ready=1.
REQ-032 Reset values: tx_valid, src_rd, snk_we, done, busy=0; tx_data, src_addr, snk_addr, snk_data, result, status_byte, cycle_count=0.

Verification
REQ-033 op 0x01, ACK 0xAA, src word i=16'h0100+i, tx_ready=1 -> 129 bytes: 01,AA-wait,00,01,01,01,...,3F,01; done, result 00.
REQ-034 op 0x03, ACK then 128 bytes k=0..127 value k -> 64 snk_we pulses, snk_addr i, snk_data={2i+1,2i}; done, result 00.
REQ-035 op 0x05, rx AA,02,34,12,00 -> status_byte 02, cycle_count 0x001234, result 00.
REQ-036 op 0x02, rx 0x55 -> no payload sent, done, result 01; op 0x09 -> no tx byte, result 11.
REQ-037 TIMEOUT_CYCLES=16, op 0x05, rx AA,07 then silence -> done 16 cycles after byte 07, result 10, status_byte unchanged.
REQ-038 rst asserted mid-0x01 payload with tx_ready=0 -> next cycle tx_valid=0, busy=0, no done, cmd_ready=1.

Source files
------------

// File: rtl/tpu_link_if.sv
// Command, byte-link, source-memory and sink-memory signals of the TPU link initiator.
// master = initiator side, slave = host/link/memory side.
interface tpu_link_if;
    logic        cmd_valid;
    logic [7:0]  cmd_op;
    logic        cmd_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        src_rd;
    logic [5:0]  src_addr;
    logic [15:0] src_data;
    logic        snk_we;
    logic [5:0]  snk_addr;
    logic [15:0] snk_data;
    logic        busy;
    logic        done;
    logic [1:0]  result;
    logic [7:0]  status_byte;
    logic [23:0] cycle_count;

    modport master (
        input  cmd_valid, cmd_op, tx_ready, rx_data, rx_valid, src_data,
        output cmd_ready, tx_data, tx_valid, src_rd, src_addr,
               snk_we, snk_addr, snk_data, busy, done, result, status_byte, cycle_count
    );

    modport slave (
        output cmd_valid, cmd_op, tx_ready, rx_data, rx_valid, src_data,
        input  cmd_ready, tx_data, tx_valid, src_rd, src_addr,
               snk_we, snk_addr, snk_data, busy, done, result, status_byte, cycle_count
    );
endinterface

// File: rtl/tpu_link_initiator.sv
// Runs one opcode over a byte link: command byte, ACK, then matrix write/read or status fetch.
// Latency: command byte offered the cycle after acceptance; each payload word takes 2 fetch cycles + 2 bytes.
// Backpressure: tx holds byte until tx_ready (no timeout there); rx cannot be stalled, response gaps time out.
module tpu_link_initiator #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int PAYLOAD_WORDS  = 64
) (
    input  logic clk,
    input  logic rst,
    tpu_link_if.master link
);

    typedef enum logic [3:0] {
        IDLE, SEND_CMD, WAIT_ACK, FETCH, SEND_LO, SEND_HI,
        RECV_LO, RECV_HI, RECV_STAT, FINISH
    } state_t;

    localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]     LAST_IDX = 6'(PAYLOAD_WORDS - 1);

    localparam logic [1:0] RES_OK    = 2'b00;
    localparam logic [1:0] RES_NACK  = 2'b01;
    localparam logic [1:0] RES_TMO   = 2'b10;
    localparam logic [1:0] RES_PROTO = 2'b11;

    state_t        state;
    logic [7:0]    op;
    logic [5:0]    idx;
    logic          fetch_wait;
    logic [7:0]    word_hi;
    logic [7:0]    lo_byte;
    logic [1:0]    stat_cnt;
    logic [23:0]   stat_sh;
    logic [TW-1:0] tmo_cnt;
    logic          waiting;
    logic          tmo_hit;

    assign waiting = (state == WAIT_ACK) || (state == RECV_LO) ||
                     (state == RECV_HI)  || (state == RECV_STAT);
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            op               <= '0;
            idx              <= '0;
            fetch_wait       <= 1'b0;
            word_hi          <= '0;
            lo_byte          <= '0;
            stat_cnt         <= '0;
            stat_sh          <= '0;
            tmo_cnt          <= '0;
            link.cmd_ready   <= 1'b1;
            link.tx_valid    <= 1'b0;
            link.tx_data     <= '0;
            link.src_rd      <= 1'b0;
            link.src_addr    <= '0;
            link.snk_we      <= 1'b0;
            link.snk_addr    <= '0;
            link.snk_data    <= '0;
            link.busy        <= 1'b0;
            link.done        <= 1'b0;
            link.result      <= '0;
            link.status_byte <= '0;
            link.cycle_count <= '0;
        end else begin
            link.src_rd <= 1'b0;
            link.snk_we <= 1'b0;
            link.done   <= 1'b0;
            // Every wait-to-wait transition happens on rx_valid, so this also clears on state entry.
            tmo_cnt <= (waiting && !link.rx_valid) ? tmo_cnt + 1'b1 : '0;

            case (state)
                IDLE: begin
                    if (link.cmd_valid && link.cmd_ready) begin
                        op             <= link.cmd_op;
                        link.cmd_ready <= 1'b0;
                        link.busy      <= 1'b1;
                        if (link.cmd_op >= 8'h01 && link.cmd_op <= 8'h08) begin
                            state         <= SEND_CMD;
                            link.tx_valid <= 1'b1;
                            link.tx_data  <= link.cmd_op;
                        end else begin
                            state       <= FINISH;
                            link.done   <= 1'b1;
                            link.result <= RES_PROTO;
                        end
                    end
                end
                SEND_CMD: begin
                    if (link.tx_ready) begin
                        link.tx_valid <= 1'b0;
                        state         <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (link.rx_valid) begin
                        idx <= '0;
                        if (link.rx_data == 8'hAA) begin
                            case (op)
                                8'h01, 8'h02: begin
                                    state         <= FETCH;
                                    fetch_wait    <= 1'b0;
                                    link.src_rd   <= 1'b1;
                                    link.src_addr <= '0;
                                end
                                8'h03, 8'h07, 8'h08: state <= RECV_LO;
                                8'h05: begin
                                    state    <= RECV_STAT;
                                    stat_cnt <= '0;
                                end
                                default: begin
                                    state       <= FINISH;
                                    link.done   <= 1'b1;
                                    link.result <= RES_OK;
                                end
                            endcase
                        end else begin
                            state       <= FINISH;
                            link.done   <= 1'b1;
                            link.result <= (link.rx_data == 8'h55) ? RES_NACK : RES_PROTO;
                        end
                    end else if (tmo_hit) begin
                        state       <= FINISH;
                        link.done   <= 1'b1;
                        link.result <= RES_TMO;
                    end
                end
                FETCH: begin
                    // src_data is valid only in the second FETCH cycle.
                    if (!fetch_wait) begin
                        fetch_wait <= 1'b1;
                    end else begin
                        fetch_wait    <= 1'b0;
                        link.tx_data  <= link.src_data[7:0];
                        word_hi       <= link.src_data[15:8];
                        link.tx_valid <= 1'b1;
                        state         <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (link.tx_ready) begin
                        link.tx_data <= word_hi;
                        state        <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (link.tx_ready) begin
                        link.tx_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state       <= FINISH;
                            link.done   <= 1'b1;
                            link.result <= RES_OK;
                        end else begin
                            idx           <= idx + 6'd1;
                            link.src_rd   <= 1'b1;
                            link.src_addr <= idx + 6'd1;
                            state         <= FETCH;
                        end
                    end
                end
                RECV_LO: begin
                    if (link.rx_valid) begin
                        lo_byte <= link.rx_data;
                        state   <= RECV_HI;
                    end else if (tmo_hit) begin
                        state       <= FINISH;
                        link.done   <= 1'b1;
                        link.result <= RES_TMO;
                    end
                end
                RECV_HI: begin
                    if (link.rx_valid) begin
                        link.snk_we   <= 1'b1;
                        link.snk_addr <= idx;
                        link.snk_data <= {link.rx_data, lo_byte};
                        if (idx == LAST_IDX) begin
                            state       <= FINISH;
                            link.done   <= 1'b1;
                            link.result <= RES_OK;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= RECV_LO;
                        end
                    end else if (tmo_hit) begin
                        state       <= FINISH;
                        link.done   <= 1'b1;
                        link.result <= RES_TMO;
                    end
                end
                RECV_STAT: begin
                    if (link.rx_valid) begin
                        stat_cnt <= stat_cnt + 2'd1;
                        case (stat_cnt)
                            2'd0: stat_sh[7:0]   <= link.rx_data;
                            2'd1: stat_sh[15:8]  <= link.rx_data;
                            2'd2: stat_sh[23:16] <= link.rx_data;
                            default: begin
                                // Visible status only changes once the full 4-byte record is in.
                                link.status_byte <= stat_sh[7:0];
                                link.cycle_count <= {link.rx_data, stat_sh[23:16], stat_sh[15:8]};
                                state            <= FINISH;
                                link.done        <= 1'b1;
                                link.result      <= RES_OK;
                            end
                        endcase
                    end else if (tmo_hit) begin
                        state       <= FINISH;
                        link.done   <= 1'b1;
                        link.result <= RES_TMO;
                    end
                end
                FINISH: begin
                    state          <= IDLE;
                    link.cmd_ready <= 1'b1;
                    link.busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_link_initiator.sv
// Directed bench for tpu_link_initiator: write, read, status, NACK, illegal op, timeout and mid-transfer reset.
module tb_tpu_link_initiator;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tpu_link_if link ();

    tpu_link_initiator #(.TIMEOUT_CYCLES(16), .PAYLOAD_WORDS(64)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memory: word i holds 16'h0100 + i, read data valid the cycle after src_rd.
    always_ff @(posedge clk) begin
        if (link.src_rd) link.src_data <= 16'h0100 + {10'd0, link.src_addr};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns one negedge later.
    task automatic issue(input logic [7:0] op);
        link.cmd_valid = 1'b1;
        link.cmd_op    = op;
        chk("cmd_ready_idle", 32'(link.cmd_ready), 32'd1);
        @(negedge clk);
        link.cmd_valid = 1'b0;
    endtask

    // Returns the next transferred byte; ends at the negedge after the transfer edge.
    task automatic get_tx(output logic [7:0] b, output logic ok);
        ok = 1'b0;
        b  = '0;
        for (int i = 0; i < 50; i++) begin
            if (link.tx_valid && link.tx_ready) begin
                b  = link.tx_data;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
    endtask

    task automatic rx_send(input logic [7:0] b);
        link.rx_valid = 1'b1;
        link.rx_data  = b;
        @(negedge clk);
        link.rx_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag, input logic [1:0] res);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (link.done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(ok), 32'd1);
        chk({tag, "_result"}, 32'(link.result), 32'(res));
        @(negedge clk);
        chk({tag, "_idle"}, 32'({link.done, link.cmd_ready, link.busy}), 32'b010);
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        link.cmd_valid = 1'b0;
        link.cmd_op    = '0;
        link.tx_ready  = 1'b1;
        link.rx_valid  = 1'b0;
        link.rx_data   = '0;
        link.src_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({link.cmd_ready, link.busy, link.tx_valid, link.done, link.src_rd, link.snk_we}), 32'b100000);
        chk("rst_data", 32'({link.result, link.tx_data, link.status_byte}), 32'd0);
        chk("rst_cnt", 32'(link.cycle_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Opcode 0x01 matrix write with a tx_ready stall on word 2.
        issue(8'h01);
        chk("cmd_echo", 32'({link.tx_valid, link.tx_data}), 32'h101);
        get_tx(b, ok);
        chk("cmd_byte", 32'({ok, b}), 32'h101);
        chk("ack_quiet", 32'(link.tx_valid), 32'd0);
        rx_send(8'hAA);
        for (int j = 0; j < 128; j++) begin
            if (j == 4) begin
                link.tx_ready = 1'b0;
                repeat (3) @(negedge clk);
                chk("hold_byte", 32'({link.tx_valid, link.tx_data}), 32'h102);
                link.tx_ready = 1'b1;
            end
            if (j == 64) chk("busy_mid", 32'(link.busy), 32'd1);
            get_tx(b, ok);
            chk("wr_byte", 32'({ok, b}), 32'({1'b1, ((j % 2) == 1) ? 8'h01 : 8'(j / 2)}));
        end
        expect_done("wr", 2'b00);

        // Opcode 0x03 matrix read: byte k carries value k.
        issue(8'h03);
        get_tx(b, ok);
        chk("rd_cmd", 32'({ok, b}), 32'h103);
        rx_send(8'hAA);
        for (int k = 0; k < 128; k++) begin
            rx_send(8'(k));
            if ((k % 2) == 1)
                chk("rd_word", 32'({link.snk_we, link.snk_addr, link.snk_data}),
                    32'({1'b1, 6'(k / 2), 8'(k), 8'(k - 1)}));
            else
                chk("rd_no_we", 32'(link.snk_we), 32'd0);
        end
        expect_done("rd", 2'b00);

        // Opcode 0x05 status fetch.
        issue(8'h05);
        get_tx(b, ok);
        chk("st_cmd", 32'({ok, b}), 32'h105);
        rx_send(8'hAA);
        rx_send(8'h02);
        rx_send(8'h34);
        rx_send(8'h12);
        rx_send(8'h00);
        chk("st_byte", 32'(link.status_byte), 32'h02);
        chk("st_count", 32'(link.cycle_count), 32'h001234);
        expect_done("st", 2'b00);

        // NACK, illegal opcode, and a no-payload opcode.
        issue(8'h02);
        get_tx(b, ok);
        chk("nack_cmd", 32'({ok, b}), 32'h102);
        rx_send(8'h55);
        chk("nack_notx", 32'(link.tx_valid), 32'd0);
        expect_done("nack", 2'b01);
        issue(8'h09);
        chk("ill_notx", 32'(link.tx_valid), 32'd0);
        expect_done("ill", 2'b11);
        issue(8'h04);
        get_tx(b, ok);
        chk("op4_cmd", 32'({ok, b}), 32'h104);
        rx_send(8'hAA);
        expect_done("op4", 2'b00);

        // Partial status then silence: timeout 16 edges after byte 07.
        issue(8'h05);
        get_tx(b, ok);
        chk("tmo_cmd", 32'({ok, b}), 32'h105);
        rx_send(8'hAA);
        rx_send(8'h07);
        repeat (15) @(negedge clk);
        chk("tmo_early", 32'(link.done), 32'd0);
        @(negedge clk);
        chk("tmo_done", 32'(link.done), 32'd1);
        chk("tmo_keep", 32'({link.status_byte, link.cycle_count}), 32'h02001234);
        expect_done("tmo", 2'b10);

        // Reset mid-payload while stalled on tx_ready.
        issue(8'h01);
        get_tx(b, ok);
        rx_send(8'hAA);
        for (int j = 0; j < 3; j++) get_tx(b, ok);
        link.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst", 32'({link.tx_valid, link.busy}), 32'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort", 32'({link.tx_valid, link.busy, link.done, link.cmd_ready}), 32'b0001);
        chk("rst_clear", 32'({link.status_byte, link.cycle_count}), 32'd0);
        rst = 1'b0;
        link.tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst", 32'({link.done, link.busy, link.cmd_ready}), 32'b001);
        issue(8'h06);
        get_tx(b, ok);
        chk("rec_cmd", 32'({ok, b}), 32'h106);
        rx_send(8'hAA);
        expect_done("rec", 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
